wm_cycle_sequencer: RTL
=======================

// Module: wm_cycle_sequencer
// PURPOSE
//  Sequences one washing-machine unit through fill/wash/drain/rinse/spin using the
//  programmed wash, rinse, spin and cloth values, driving valve/motor/drain/door actuators.
//  One instance per machine (units 1 and 2) sits between the appliance selector and the
//  washing-machine output registers, replacing direct register loads with timed phases.
// PARAMETERS
//  TICKS_PER_MIN  4   clk cycles per minute tick (internal prescaler); >=1
//  DRAIN_MIN      2   fixed drain phase length in minutes (1..3)
//  MAX_CLOTH      10  largest legal cloth load; fill lasts cloth minutes
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  level; sampled in IDLE/DONE, latches settings, begins cycle
//  pause      in   1  level; freezes timing while high in an active phase
//  abort      in   1  level; forces safe drain then IDLE; also clears ERROR
//  wash       in   5  wash minutes (0 = skip phase)
//  rinse      in   5  rinse minutes (0 = skip)
//  spin       in   5  spin minutes (0 = skip)
//  cloth      in   5  load size; fill minutes; legal 1..MAX_CLOTH
//  state      out  3  IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6 ERROR=7
//  remaining  out  7  minutes left in whole cycle (current phase + later phases)
//  valve_on   out  1  FILL or RINSE, not paused
//  motor_on   out  1  WASH, RINSE or SPIN, not paused
//  drain_on   out  1  DRAIN or SPIN, not paused
//  door_lock  out  1  high in states 1..5 (incl. paused)
//  done       out  1  one-cycle pulse on the edge that enters DONE
// BEHAVIOUR
//  - Reset: state=IDLE, remaining=0, all actuators/done/door_lock 0, counters and latches 0.
//  - All outputs registered (or decoded from registered state/flags); no comb path input->output.
//  - Start: in IDLE/DONE with start=1, abort=0 -> latch wash/rinse/spin/cloth; next state FILL,
//    or ERROR if cloth==0 or cloth>MAX_CLOTH. Inputs ignored after latch until next start.
//  - Phase order FILL(cloth) -> WASH(wash) -> DRAIN(DRAIN_MIN) -> RINSE(rinse) -> SPIN(spin) -> DONE.
//  - Phase entry loads min_cnt with duration, prescaler=0. Prescaler counts 0..TICKS_PER_MIN-1;
//    wrap = minute tick, min_cnt-1. Tick with min_cnt==1 -> next phase. d-minute phase lasts
//    exactly d*TICKS_PER_MIN cycles; zero-length phase lasts exactly 1 cycle, actuators off.
//  - remaining = min_cnt + latched durations of later phases (max 31+31+2+31+31=126, 7 bits);
//    in DRAIN/SPIN of abort-drain = min_cnt only; 0 in IDLE/DONE/ERROR.
//  - Pause (active phases only): prescaler and min_cnt hold, actuators 0, door_lock stays 1;
//    release resumes same count, no cycle lost or repeated. Pause ignored in IDLE/DONE/ERROR.
//  - Abort in states 1..5: next state DRAIN, min_cnt=DRAIN_MIN, abort_flag=1; at end of that
//    drain -> IDLE, no done pulse. Abort already draining does not restart drain.
//    Abort in ERROR -> IDLE. Abort in IDLE/DONE: no effect.
//  - Priority: abort > pause > timing; abort and start same cycle in IDLE -> stay IDLE.
//  - DONE holds (door unlocked) until start begins a new cycle; done not re-pulsed while held.
//  - ERROR holds, all actuators 0, until abort.
//  - rst_n low mid-cycle: immediate return to reset values regardless of clk.
// TESTING (TICKS_PER_MIN=4, DRAIN_MIN=2, MAX_CLOTH=10)
//  1 wash=3 rinse=2 spin=1 cloth=2, start 1 cycle -> remaining=10 after latch; FILL 8, WASH 12,
//    DRAIN 8, RINSE 8, SPIN 4 cycles; done pulses once exactly 40 cycles after FILL entry.
//  2 wash=0 rinse=0 spin=0 cloth=1 -> FILL 4, WASH 1, DRAIN 8, RINSE 1, SPIN 1, DONE; motor never high.
//  3 cloth=0 (and separately cloth=11) with start -> state=ERROR, door_lock=0; abort -> IDLE.
//  4 pause 6 cycles mid-WASH -> motor_on=0, remaining frozen, door_lock=1; done 6 cycles later
//    than scenario 1.
//  5 abort during RINSE -> next state DRAIN, drain_on=1 for 8 cycles, then IDLE, done never pulses.
//  6 rst_n low mid-SPIN -> all outputs 0, state=IDLE same cycle; start+abort together -> stays IDLE.

Source files
------------

// File: rtl/wm_cycle_sequencer.sv
// wm_cycle_sequencer
//   Runs one washing-machine unit through its timed phases:
//   FILL (cloth) -> WASH (wash) -> DRAIN (DRAIN_MIN) -> RINSE (rinse) -> SPIN (spin) -> DONE.
//   The wash, rinse, spin and cloth settings are captured on start. Each phase is then
//   counted in minute ticks produced by an internal prescaler. The block drives the
//   valve, motor, drain and door-lock actuators.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level; begins a cycle from IDLE/DONE and captures the settings
//   pause      level; freezes timing and drops actuators during an active phase
//   abort      level; forces a safe drain then IDLE, and clears ERROR
//   wash/rinse/spin   phase lengths in minutes (0 skips the phase)
//   cloth      load size; this is also the fill length in minutes (legal 1..MAX_CLOTH)
//   state      IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6 ERROR=7
//   remaining  minutes left in the whole cycle
//   valve_on/motor_on/drain_on/door_lock  actuator controls
//   done       one-cycle pulse on entry to DONE
module wm_cycle_sequencer #(
  parameter int TICKS_PER_MIN = 4,
  parameter int DRAIN_MIN     = 2,
  parameter int MAX_CLOTH     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [4:0] wash,
  input  logic [4:0] rinse,
  input  logic [4:0] spin,
  input  logic [4:0] cloth,
  output logic [2:0] state,
  output logic [6:0] remaining,
  output logic       valve_on,
  output logic       motor_on,
  output logic       drain_on,
  output logic       door_lock,
  output logic       done
);

  localparam int            PW         = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [4:0]    DRAIN_LEN  = 5'(DRAIN_MIN);
  localparam logic [4:0]    CLOTH_MAX  = 5'(MAX_CLOTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    min_cnt_q, min_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    wash_q, wash_d;
  logic [4:0]    rinse_q, rinse_d;
  logic [4:0]    spin_q, spin_d;
  logic [4:0]    cloth_q, cloth_d;
  logic          abort_flag_q, abort_flag_d;
  logic          paused_q, paused_d;
  logic          done_q, done_d;
  logic          phase_end;
  logic          abort_run;
  state_t        nxt_phase;

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_FILL:  next_phase = S_WASH;
      S_WASH:  next_phase = S_DRAIN;
      S_DRAIN: next_phase = S_RINSE;
      S_RINSE: next_phase = S_SPIN;
      default: next_phase = S_DONE;
    endcase
  endfunction

  function automatic logic [4:0] phase_len(input state_t s, input logic [4:0] w,
                                           input logic [4:0] r, input logic [4:0] sp);
    case (s)
      S_WASH:  phase_len = w;
      S_DRAIN: phase_len = DRAIN_LEN;
      S_RINSE: phase_len = r;
      S_SPIN:  phase_len = sp;
      default: phase_len = 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] ext7(input logic [4:0] v);
    ext7 = {2'b00, v};
  endfunction

  always_comb begin
    state_d      = state_q;
    min_cnt_d    = min_cnt_q;
    presc_d      = presc_q;
    wash_d       = wash_q;
    rinse_d      = rinse_q;
    spin_d       = spin_q;
    cloth_d      = cloth_q;
    abort_flag_d = abort_flag_q;
    paused_d     = 1'b0;
    phase_end    = 1'b0;
    abort_run    = abort_flag_q | abort;
    nxt_phase    = next_phase(state_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          wash_d       = wash;
          rinse_d      = rinse;
          spin_d       = spin;
          cloth_d      = cloth;
          abort_flag_d = 1'b0;
          presc_d      = '0;
          if (cloth == 5'd0 || cloth > CLOTH_MAX) begin
            state_d   = S_ERROR;
            min_cnt_d = 5'd0;
          end else begin
            state_d   = S_FILL;
            min_cnt_d = cloth;
          end
        end
      end
      S_ERROR: begin
        if (abort) state_d = S_IDLE;
      end
      default: begin
        if (abort && state_q != S_DRAIN) begin
          state_d      = S_DRAIN;
          min_cnt_d    = DRAIN_LEN;
          presc_d      = '0;
          abort_flag_d = 1'b1;
        end else begin
          // Abort while already draining only marks the drain as the last phase.
          if (abort) abort_flag_d = 1'b1;
          if (pause && !abort) begin
            paused_d = 1'b1;
          end else if (min_cnt_q == 5'd0) begin
            // A zero-length phase occupies exactly one cycle.
            phase_end = 1'b1;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (min_cnt_q == 5'd1) phase_end = 1'b1;
            else                   min_cnt_d = min_cnt_q - 5'd1;
          end else begin
            presc_d = presc_q + PW'(1);
          end

          if (phase_end) begin
            presc_d = '0;
            if (state_q == S_DRAIN && abort_run) begin
              state_d      = S_IDLE;
              min_cnt_d    = 5'd0;
              abort_flag_d = 1'b0;
            end else begin
              state_d   = nxt_phase;
              min_cnt_d = phase_len(nxt_phase, wash_q, rinse_q, spin_q);
            end
          end
        end
      end
    endcase

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      min_cnt_q    <= 5'd0;
      presc_q      <= '0;
      wash_q       <= 5'd0;
      rinse_q      <= 5'd0;
      spin_q       <= 5'd0;
      cloth_q      <= 5'd0;
      abort_flag_q <= 1'b0;
      paused_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_cnt_q    <= min_cnt_d;
      presc_q      <= presc_d;
      wash_q       <= wash_d;
      rinse_q      <= rinse_d;
      spin_q       <= spin_d;
      cloth_q      <= cloth_d;
      abort_flag_q <= abort_flag_d;
      paused_q     <= paused_d;
      done_q       <= done_d;
    end
  end

  // Remaining time is the current phase count plus every later phase still to run.
  always_comb begin
    remaining = 7'd0;
    case (state_q)
      S_FILL:  remaining = ext7(min_cnt_q) + ext7(wash_q) + ext7(DRAIN_LEN)
                           + ext7(rinse_q) + ext7(spin_q);
      S_WASH:  remaining = ext7(min_cnt_q) + ext7(DRAIN_LEN) + ext7(rinse_q) + ext7(spin_q);
      S_DRAIN: remaining = abort_flag_q ? ext7(min_cnt_q)
                                        : ext7(min_cnt_q) + ext7(rinse_q) + ext7(spin_q);
      S_RINSE: remaining = ext7(min_cnt_q) + ext7(spin_q);
      S_SPIN:  remaining = ext7(min_cnt_q);
      default: remaining = 7'd0;
    endcase
  end

  // A zero count in an active phase marks a skipped phase, so its actuators stay off.
  assign state     = state_q;
  assign valve_on  = (state_q == S_FILL  || state_q == S_RINSE) && !paused_q && (min_cnt_q != 5'd0);
  assign motor_on  = (state_q == S_WASH  || state_q == S_RINSE || state_q == S_SPIN)
                     && !paused_q && (min_cnt_q != 5'd0);
  assign drain_on  = (state_q == S_DRAIN || state_q == S_SPIN) && !paused_q && (min_cnt_q != 5'd0);
  assign door_lock = (state_q >= S_FILL) && (state_q <= S_SPIN);
  assign done      = done_q;

endmodule
